// File: rtl/ram1_uart_arbiter.sv
// Arbiter for the shared RAM1 bus: sequences SRAM read/write strobes and UART rdn/wrn so they never contend.
// Define ARB_SYNC_EN to add 2-flop synchronizers on data_ready/tbre/tsre.
module ram1_uart_arbiter #(
   parameter int unsigned ADDR_W     = 18,
   parameter int unsigned RD_CYCLES  = 2,
   parameter int unsigned WR_CYCLES  = 2,
   parameter int unsigned UART_PULSE = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [15:0]       mem_wdata,
   output logic              mem_ack,
   output logic [15:0]       mem_rdata,
   input  logic              tx_req,
   input  logic [7:0]        tx_data,
   output logic              tx_ack,
   output logic              rx_valid,
   output logic [7:0]        rx_data,
   output logic              busy,
   output logic [ADDR_W-1:0] ram_addr1,
   inout  wire  [15:0]       ram_data1,
   output logic              ram1EN,
   output logic              ram1OE,
   output logic              ram1WE,
   output logic              rdn,
   output logic              wrn,
   input  logic              data_ready,
   input  logic              tbre,
   input  logic              tsre
);

   localparam int unsigned MAX_RW  = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_RW > UART_PULSE) ? MAX_RW : UART_PULSE;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_MEM_RD, S_MEM_WR, S_MEM_WR_HOLD,
      S_UART_RD, S_UART_WR, S_WAIT_TBRE, S_WAIT_TSRE
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_last, w_last_nxt;       // 1 = uart granted last
   logic [15:0]        r_dout, w_dout_nxt;
   logic               r_drive, w_drive_nxt;
   logic [ADDR_W-1:0]  w_addr_nxt;
   logic               w_mem_ack_nxt, w_tx_ack_nxt, w_rx_valid_nxt;
   logic               w_cap_mem, w_cap_rx;
   logic               w_en_n, w_oe_n, w_we_n, w_rdn, w_wrn, w_busy;
   logic               w_data_ready, w_tbre, w_tsre;
   logic               w_mem_rq, w_rx_rq, w_tx_rq, w_uart_rq;

`ifdef ARB_SYNC_EN
   logic [2:0] r_sync1, r_sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= {data_ready, tbre, tsre};
         r_sync2 <= r_sync1;
      end
   end

   assign {w_data_ready, w_tbre, w_tsre} = r_sync2;
`else
   assign {w_data_ready, w_tbre, w_tsre} = {data_ready, tbre, tsre};
`endif

   // The registered ack of a port masks that port for its ack cycle
   assign w_mem_rq  = mem_req && !mem_ack;
   assign w_rx_rq   = w_data_ready && !rx_valid;
   assign w_tx_rq   = tx_req && !tx_ack;
   assign w_uart_rq = w_rx_rq || w_tx_rq;

   assign ram_data1 = r_drive ? r_dout : 16'hzzzz;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_last    <= 1'b1;
         r_dout    <= '0;
         r_drive   <= 1'b0;
         ram_addr1 <= '0;
         mem_ack   <= 1'b0;
         tx_ack    <= 1'b0;
         rx_valid  <= 1'b0;
         busy      <= 1'b0;
         mem_rdata <= '0;
         rx_data   <= '0;
         ram1EN    <= 1'b1;
         ram1OE    <= 1'b1;
         ram1WE    <= 1'b1;
         rdn       <= 1'b1;
         wrn       <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_last    <= w_last_nxt;
         r_dout    <= w_dout_nxt;
         r_drive   <= w_drive_nxt;
         ram_addr1 <= w_addr_nxt;
         mem_ack   <= w_mem_ack_nxt;
         tx_ack    <= w_tx_ack_nxt;
         rx_valid  <= w_rx_valid_nxt;
         busy      <= w_busy;
         ram1EN    <= w_en_n;
         ram1OE    <= w_oe_n;
         ram1WE    <= w_we_n;
         rdn       <= w_rdn;
         wrn       <= w_wrn;
         if (w_cap_mem) mem_rdata <= ram_data1;
         if (w_cap_rx)  rx_data   <= ram_data1[7:0];
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_last_nxt     = r_last;
      w_dout_nxt     = r_dout;
      w_addr_nxt     = ram_addr1;
      w_mem_ack_nxt  = 1'b0;
      w_tx_ack_nxt   = 1'b0;
      w_rx_valid_nxt = 1'b0;
      w_cap_mem      = 1'b0;
      w_cap_rx       = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            // Round-robin between classes: mem wins unless it was granted last
            if (w_mem_rq && (!w_uart_rq || r_last)) begin
               w_last_nxt  = 1'b0;
               w_addr_nxt  = mem_addr;
               w_dout_nxt  = mem_wdata;
               w_state_nxt = mem_we ? S_MEM_WR : S_MEM_RD;
            end else if (w_uart_rq) begin
               w_last_nxt = 1'b1;
               if (w_rx_rq) begin
                  w_state_nxt = S_UART_RD;
               end else begin
                  w_dout_nxt  = {8'h00, tx_data};
                  w_state_nxt = S_UART_WR;
               end
            end
         end
         S_MEM_RD: begin
            if (r_cnt == CNT_W'(RD_CYCLES - 1)) begin
               w_state_nxt   = S_IDLE;
               w_cap_mem     = 1'b1;
               w_mem_ack_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_MEM_WR: begin
            if (r_cnt == CNT_W'(WR_CYCLES - 1)) begin
               w_state_nxt = S_MEM_WR_HOLD;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_MEM_WR_HOLD: begin
            w_state_nxt   = S_IDLE;
            w_mem_ack_nxt = 1'b1;
         end
         S_UART_RD: begin
            if (r_cnt == CNT_W'(UART_PULSE - 1)) begin
               w_state_nxt    = S_IDLE;
               w_cap_rx       = 1'b1;
               w_rx_valid_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_UART_WR: begin
            if (r_cnt == CNT_W'(UART_PULSE - 1)) begin
               w_state_nxt = S_WAIT_TBRE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_WAIT_TBRE: begin
            if (w_tbre) w_state_nxt = S_WAIT_TSRE;
         end
         S_WAIT_TSRE: begin
            if (w_tsre) begin
               w_state_nxt  = S_IDLE;
               w_tx_ack_nxt = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Strobes are decoded from the next state so they come straight out of flops
      w_en_n      = !(w_state_nxt == S_MEM_RD || w_state_nxt == S_MEM_WR ||
                      w_state_nxt == S_MEM_WR_HOLD);
      w_oe_n      = (w_state_nxt != S_MEM_RD);
      w_we_n      = (w_state_nxt != S_MEM_WR);
      w_rdn       = (w_state_nxt != S_UART_RD);
      w_wrn       = (w_state_nxt != S_UART_WR);
      w_drive_nxt = (w_state_nxt == S_MEM_WR || w_state_nxt == S_MEM_WR_HOLD ||
                     w_state_nxt == S_UART_WR);
      w_busy      = (w_state_nxt != S_IDLE);
   end

endmodule
